// File: rtl/cache_pkg.sv
// Shared widths and controller state type for the direct-mapped cache.
package cache_pkg;

    localparam int CACHE_ADDR_W  = 32;
    localparam int CACHE_INDEX_W = 10;
    localparam int CACHE_DATA_W  = 32;
    localparam int CACHE_TAG_W   = CACHE_ADDR_W - CACHE_INDEX_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_MEM_RD,
        ST_MEM_WR,
        ST_FLUSH
    } cache_state_e;

endpackage

// File: rtl/cache_flush_seq.sv
// Invalidate-sweep sequencer: line counter, last-line flag and end-of-sweep pulse.
module cache_flush_seq
    import cache_pkg::*;
#(
    parameter int INDEX_W = CACHE_INDEX_W
) (
    input  logic               globalclock,
    input  logic               reset,
    input  logic               active_i,
    output logic [INDEX_W-1:0] cnt_o,
    output logic               last_o,
    output logic               done_o
);

    logic [INDEX_W-1:0] cnt_q, cnt_d;
    logic               done_q, done_d;

    assign last_o = (cnt_q == '1);

    // The counter wraps back to 0 after the last line, ready for the next sweep.
    always_comb begin
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (active_i) begin
            cnt_d  = cnt_q + 1'b1;
            done_d = last_o;
        end
    end

    always_ff @(posedge globalclock) begin
        if (reset) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign done_o = done_q;

endmodule

// File: rtl/dm_cache_controller.sv
// Direct-mapped cache sequencer: CPU request handling, line-store writes,
// RAM refill / write-through, and whole-cache invalidate sweep.
module dm_cache_controller
    import cache_pkg::*;
#(
    parameter  int ADDR_W  = CACHE_ADDR_W,
    parameter  int INDEX_W = CACHE_INDEX_W,
    parameter  int DATA_W  = CACHE_DATA_W,
    localparam int TAG_W   = ADDR_W - INDEX_W
) (
    input  logic               globalclock,
    input  logic               reset,

    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [ADDR_W-1:0]  cpu_addr,
    input  logic [DATA_W-1:0]  cpu_wdata,
    output logic [DATA_W-1:0]  cpu_rdata,
    output logic               cpu_ready,
    output logic               cpu_busy,

    input  logic               inv_all,
    output logic               flush_done,

    output logic               v_wr_en,
    output logic [INDEX_W-1:0] v_addr,
    output logic               v_in,
    input  logic               v_is_valid,

    output logic               tag_wr_en,
    output logic [TAG_W-1:0]   tag_wdata,
    input  logic [TAG_W-1:0]   tag_rdata,

    output logic               data_wr_en,
    output logic [DATA_W-1:0]  data_wdata,
    input  logic [DATA_W-1:0]  data_rdata,

    output logic               mem_req,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata,
    input  logic               mem_ack
);

    cache_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               we_q, we_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               ready_q, ready_d;

    logic               flush_active;
    logic [INDEX_W-1:0] flush_cnt;
    logic               flush_last;
    logic               hit;

    assign flush_active = (state_q == ST_FLUSH);

    cache_flush_seq #(
        .INDEX_W (INDEX_W)
    ) u_flush (
        .globalclock (globalclock),
        .reset       (reset),
        .active_i    (flush_active),
        .cnt_o       (flush_cnt),
        .last_o      (flush_last),
        .done_o      (flush_done)
    );

    assign hit       = v_is_valid && (tag_rdata == addr_q[ADDR_W-1:INDEX_W]);
    assign cpu_busy  = (state_q != ST_IDLE);
    assign cpu_ready = ready_q;
    assign cpu_rdata = rdata_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        ready_d    = 1'b0;
        v_wr_en    = 1'b0;
        v_in       = 1'b0;
        v_addr     = addr_q[INDEX_W-1:0];
        tag_wr_en  = 1'b0;
        tag_wdata  = '0;
        data_wr_en = 1'b0;
        data_wdata = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;

        unique case (state_q)
            ST_IDLE: begin
                v_addr = cpu_addr[INDEX_W-1:0];
                // Invalidate wins over a simultaneous CPU request.
                if (inv_all) begin
                    state_d = ST_FLUSH;
                end else if (cpu_req) begin
                    addr_d  = cpu_addr;
                    we_d    = cpu_we;
                    wdata_d = cpu_wdata;
                    state_d = ST_LOOKUP;
                end
            end

            ST_LOOKUP: begin
                if (we_q) begin
                    // Write-through, no allocate: only a resident line is updated.
                    if (hit) begin
                        data_wr_en = 1'b1;
                        data_wdata = wdata_q;
                    end
                    state_d = ST_MEM_WR;
                end else if (hit) begin
                    rdata_d = data_rdata;
                    ready_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_MEM_RD;
                end
            end

            ST_MEM_RD: begin
                mem_req  = 1'b1;
                mem_addr = addr_q;
                if (mem_ack) begin
                    v_wr_en    = 1'b1;
                    v_in       = 1'b1;
                    tag_wr_en  = 1'b1;
                    tag_wdata  = addr_q[ADDR_W-1:INDEX_W];
                    data_wr_en = 1'b1;
                    data_wdata = mem_rdata;
                    rdata_d    = mem_rdata;
                    ready_d    = 1'b1;
                    state_d    = ST_IDLE;
                end
            end

            ST_MEM_WR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                if (mem_ack) begin
                    ready_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            ST_FLUSH: begin
                v_wr_en = 1'b1;
                v_addr  = flush_cnt;
                if (flush_last) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge globalclock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
        end
    end

endmodule

// File: tb/tb_dm_cache_controller.sv
// Self-checking bench for dm_cache_controller: behavioural cache/RAM model plus random traffic.
module tb_dm_cache_controller;

    localparam int AW    = 32;
    localparam int IW    = 10;
    localparam int DW    = 32;
    localparam int TW    = AW - IW;
    localparam int LINES = 1 << IW;

    logic          globalclock = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          cpu_ready, cpu_busy;
    logic          inv_all, flush_done;
    logic          v_wr_en, v_in, v_is_valid;
    logic [IW-1:0] v_addr;
    logic          tag_wr_en;
    logic [TW-1:0] tag_wdata, tag_rdata;
    logic          data_wr_en;
    logic [DW-1:0] data_wdata, data_rdata;
    logic          mem_req, mem_we, mem_ack;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 globalclock = ~globalclock;

    dm_cache_controller #(
        .ADDR_W  (AW),
        .INDEX_W (IW),
        .DATA_W  (DW)
    ) dut (
        .globalclock (globalclock),
        .reset       (reset),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_ready   (cpu_ready),
        .cpu_busy    (cpu_busy),
        .inv_all     (inv_all),
        .flush_done  (flush_done),
        .v_wr_en     (v_wr_en),
        .v_addr      (v_addr),
        .v_in        (v_in),
        .v_is_valid  (v_is_valid),
        .tag_wr_en   (tag_wr_en),
        .tag_wdata   (tag_wdata),
        .tag_rdata   (tag_rdata),
        .data_wr_en  (data_wr_en),
        .data_wdata  (data_wdata),
        .data_rdata  (data_rdata),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack)
    );

    // Line stores the controller drives (environment, combinational read).
    bit [0:0]    st_v [LINES];
    bit [TW-1:0] st_t [LINES];
    bit [DW-1:0] st_d [LINES];
    int nv = 0, nt = 0, nd = 0;

    assign v_is_valid = st_v[v_addr][0];
    assign tag_rdata  = st_t[v_addr];
    assign data_rdata = st_d[v_addr];

    always @(posedge globalclock) begin
        if (v_wr_en)    begin st_v[v_addr] <= v_in;       nv <= nv + 1; end
        if (tag_wr_en)  begin st_t[v_addr] <= tag_wdata;  nt <= nt + 1; end
        if (data_wr_en) begin st_d[v_addr] <= data_wdata; nd <= nd + 1; end
    end

    // Reference: what the cache should hold, and the RAM contents.
    bit            rv   [LINES];
    bit [TW-1:0]   rt   [LINES];
    bit [DW-1:0]   rdat [LINES];
    logic [DW-1:0] ram  [bit [AW-1:0]];
    logic [DW-1:0] last_rd;

    int total = 0;
    int bad   = 0;

    function automatic logic [DW-1:0] ram_rd(input logic [AW-1:0] a);
        if (ram.exists(a)) return ram[a];
        return (a * 32'h9E37_79B1) ^ 32'hC0FF_EE00;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_op(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input int dly, input bit spur, input bit noise);
        logic [IW-1:0] idx;
        logic [TW-1:0] tg;
        bit            hit, use_mem, done, seen, acked, lk_dwe;
        int            exp_lat, cyc, waited, v0, t0, d0, ev, ed;
        logic [DW-1:0] exp_rd, m_wd;
        logic [AW-1:0] m_addr;
        logic          m_we;
        idx     = addr[IW-1:0];
        tg      = addr[AW-1:IW];
        hit     = rv[idx] && (rt[idx] == tg);
        use_mem = we || !hit;
        exp_lat = (!we && hit) ? 2 : 3 + dly;
        exp_rd  = we ? last_rd : (hit ? rdat[idx] : ram_rd(addr));
        ev      = (!we && !hit) ? 1 : 0;
        ed      = (ev == 1 || (we && hit)) ? 1 : 0;
        done = 0; seen = 0; acked = 0; waited = 0; lk_dwe = 0;
        m_addr = '0; m_we = 1'b0; m_wd = '0;

        @(negedge globalclock);
        check("ready_pulse", cpu_ready, 0);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        v0 = nv; t0 = nt; d0 = nd;
        @(posedge globalclock);
        @(negedge globalclock);
        cpu_req = 1'b0;
        cyc = 1;
        while (!done && cyc <= 40) begin
            mem_ack = 1'b0;
            if (cyc == 1) begin
                lk_dwe = data_wr_en;
                if (spur) begin mem_ack = 1'b1; mem_rdata = $urandom; end
            end
            if (cpu_ready) begin
                done = 1;
            end else begin
                if (mem_req && !acked) begin
                    if (!seen) begin seen = 1; m_addr = mem_addr; m_we = mem_we; m_wd = mem_wdata; end
                    if (waited == dly) begin
                        mem_ack = 1'b1;
                        acked   = 1;
                        if (mem_we) ram[mem_addr] = mem_wdata;
                        else        mem_rdata = ram_rd(mem_addr);
                    end else begin
                        waited++;
                    end
                end
                if (noise) begin
                    cpu_req = 1'b1; cpu_addr = $urandom; cpu_we = 1'($urandom); cpu_wdata = $urandom;
                end
                @(posedge globalclock);
                @(negedge globalclock);
                cyc++;
            end
        end
        cpu_req = 1'b0;
        mem_ack = 1'b0;

        check("complete", done, 1);
        check("latency", cyc, exp_lat);
        check("mem_used", seen, use_mem);
        if (use_mem) begin
            check("mem_addr", m_addr, addr);
            check("mem_we", m_we, we);
            if (we) check("mem_wdata", m_wd, wd);
        end
        check("rdata", cpu_rdata, exp_rd);
        check("busy_after", cpu_busy, 0);
        check("mem_req_drop", mem_req, 0);
        check("lookup_dwe", lk_dwe, we && hit);
        check("v_writes", nv - v0, ev);
        check("t_writes", nt - t0, ev);
        check("d_writes", nd - d0, ed);

        if (!we && !hit) begin rv[idx] = 1; rt[idx] = tg; rdat[idx] = exp_rd; end
        if (we && hit)   rdat[idx] = wd;
        if (!we) last_rd = exp_rd;
    endtask

    task automatic do_flush();
        int sweep_bad, v0, s;
        sweep_bad = 0;
        @(negedge globalclock);
        inv_all = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0C04;
        v0 = nv;
        @(posedge globalclock);
        @(negedge globalclock);
        inv_all = 1'b0;
        for (int k = 0; k < LINES; k++) begin
            if (!(v_wr_en && !v_in && v_addr == IW'(k) && cpu_busy && !mem_req
                  && !flush_done && !cpu_ready && !tag_wr_en && !data_wr_en))
                sweep_bad++;
            @(posedge globalclock);
            @(negedge globalclock);
        end
        check("flush_done", flush_done, 1);
        check("flush_idle", cpu_busy, 0);
        check("flush_stop", v_wr_en, 0);
        cpu_req = 1'b0;
        check("sweep_cycles_bad", sweep_bad, 0);
        check("sweep_writes", nv - v0, LINES);
        s = 0;
        for (int i = 0; i < LINES; i++) s += int'(st_v[i]);
        check("valid_cleared", s, 0);
        for (int i = 0; i < LINES; i++) rv[i] = 0;
        @(negedge globalclock);
        check("flush_done_pulse", flush_done, 0);
    endtask

    task automatic reset_mid_read();
        int v0, t0, d0, w;
        bit got_req;
        got_req = 0;
        @(negedge globalclock);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_3010;
        @(posedge globalclock);
        @(negedge globalclock);
        cpu_req = 1'b0;
        for (w = 0; w < 10 && !got_req; w++) begin
            @(posedge globalclock);
            @(negedge globalclock);
            got_req = mem_req;
        end
        check("rst_req_seen", got_req, 1);
        v0 = nv; t0 = nt; d0 = nd;
        reset = 1'b1;
        @(posedge globalclock);
        @(negedge globalclock);
        check("rst_mem_req", mem_req, 0);
        check("rst_busy", cpu_busy, 0);
        check("rst_ready", cpu_ready, 0);
        check("rst_rdata", cpu_rdata, 0);
        reset = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        @(posedge globalclock);
        @(negedge globalclock);
        mem_ack = 1'b0;
        check("late_ack_ready", cpu_ready, 0);
        check("late_ack_req", mem_req, 0);
        check("late_ack_writes", (nv - v0) + (nt - t0) + (nd - d0), 0);
        last_rd = '0;
    endtask

    initial begin
        logic [IW-1:0] idx_set [6];
        logic [AW-1:0] a;
        logic [TW-1:0] tg;
        idx_set = '{10'h004, 10'h008, 10'h010, 10'h3FF, 10'h000, 10'h155};
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        inv_all = 1'b0; mem_ack = 1'b0; mem_rdata = '0; last_rd = '0;
        repeat (3) @(negedge globalclock);
        check("rst_busy0", cpu_busy, 0);
        check("rst_ready0", cpu_ready, 0);
        check("rst_rdata0", cpu_rdata, 0);
        check("rst_mem_req0", mem_req, 0);
        check("rst_vwe0", v_wr_en, 0);
        check("rst_twe0", tag_wr_en, 0);
        check("rst_dwe0", data_wr_en, 0);
        check("rst_fdone0", flush_done, 0);
        check("rst_vaddr0", v_addr, 0);
        reset = 1'b0;

        ram[32'h0000_1004] = 32'hDEAD_BEEF;
        do_op(0, 32'h0000_1004, '0, 1, 0, 0);
        check("fill_valid", st_v[4], 1);
        check("fill_tag", st_t[4], 22'h4);
        check("fill_data", st_d[4], 32'hDEAD_BEEF);
        do_op(0, 32'h0000_1004, '0, 0, 0, 0);
        do_op(0, 32'h0000_0C04, '0, 0, 0, 0);
        check("evict_tag", st_t[4], 22'h3);
        do_op(0, 32'h0000_1004, '0, 2, 0, 0);
        do_op(0, 32'h0000_0C04, '0, 0, 0, 0);
        do_op(1, 32'h0000_0C04, 32'h1234_5678, 0, 0, 0);
        do_op(0, 32'h0000_0C04, '0, 0, 0, 0);
        check("write_hit_data", cpu_rdata, 32'h1234_5678);
        do_op(1, 32'h0000_2008, 32'hA5A5_5A5A, 1, 0, 0);
        check("write_miss_valid", st_v[8], 0);
        do_flush();
        do_op(0, 32'h0000_0C04, '0, 0, 0, 0);
        reset_mid_read();
        do_op(0, 32'h0000_3010, '0, 0, 0, 0);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_flush();
            end else begin
                tg = ($urandom_range(0, 9) == 0) ? 22'h3F_FFFF : TW'($urandom_range(0, 3));
                a  = {tg, idx_set[$urandom_range(0, 5)]};
                do_op(1'($urandom_range(0, 2) == 0), a, $urandom, $urandom_range(0, 3),
                      1'($urandom), 1'($urandom));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
